// File: rtl/ma_mem_pkg.sv
// Shared types and constants for the MA-stage data-memory responder:
// default sizing, the responder FSM state type and the byte-to-word address helper.
package ma_mem_pkg;

   localparam int unsigned MA_DATA_W  = 32;
   localparam int unsigned MA_DEPTH   = 1024;
   localparam int unsigned MA_LATENCY = 2;
   // Wide enough for the largest legal latency (15).
   localparam int unsigned MA_CNT_W   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } ma_resp_state_t;

   // Byte address to word index; bits above the array size drop out, so addresses wrap.
   function automatic logic [31:0] word_index(input logic [31:0] addr, input int unsigned depth);
      return (addr >> 2) & (depth - 1);
   endfunction

endpackage

// File: rtl/ma_resp_timer.sv
// Loadable down-counter for the responder's WAIT phase; done strobes while the
// count sits at 1, i.e. in the last waiting cycle before the response.
module ma_resp_timer
   import ma_mem_pkg::*;
#(
   parameter int unsigned CNT_W = MA_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ma_data_mem_responder.sv
// Word-addressed data memory answering MA-stage loads/stores after a fixed LATENCY.
// Optional MA_ADDR_CHECK_EN flags misaligned / out-of-range requests via resp_err.
module ma_data_mem_responder
   import ma_mem_pkg::*;
#(
   parameter int unsigned DEPTH   = MA_DEPTH,
   parameter int unsigned LATENCY = MA_LATENCY,
   parameter int unsigned DATA_W  = MA_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              stall
);

   localparam int unsigned         IDX_W       = $clog2(DEPTH);
   localparam logic [MA_CNT_W-1:0] WAIT_LOAD   = MA_CNT_W'(LATENCY - 1);
   localparam bit                  MULTI_CYCLE = (LATENCY > 1);

   ma_resp_state_t    state_d;
   ma_resp_state_t    state_q;
   logic [DATA_W-1:0] hold_d;
   logic [DATA_W-1:0] hold_q;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [IDX_W-1:0]  req_idx;
   logic              accept;
   logic              req_err;
   logic              timer_load;
   logic              timer_done;

   assign req_idx = IDX_W'(word_index(req_addr, DEPTH));

`ifdef MA_ADDR_CHECK_EN
   localparam logic [33:0] ADDR_LIMIT = 34'(DEPTH) << 2;

   logic err_d;
   logic err_q;

   assign req_err = (req_addr[1:0] != 2'b00) || ({2'b00, req_addr} >= ADDR_LIMIT);

   always_comb begin
      err_d = err_q;
      if (accept) begin
         err_d = req_err;
      end
   end

   always_ff @(posedge clk) begin
      err_q <= err_d;
   end

   assign resp_err = resp_valid & err_q;
`else
   assign req_err  = 1'b0;
   assign resp_err = 1'b0;
`endif

   // Nothing is accepted on a reset edge, so a store either commits fully or not at all.
   assign req_ready  = (state_q != WAIT);
   assign accept     = req_valid & req_ready & ~reset;
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = resp_valid ? hold_q : '0;
   assign stall      = (state_q == WAIT) | (req_valid & ~req_ready);

   ma_resp_timer #(
      .CNT_W (MA_CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load),
      .load_val (WAIT_LOAD),
      .done     (timer_done)
   );

   always_comb begin
      state_d    = state_q;
      timer_load = 1'b0;
      case (state_q)
         IDLE, RESP: begin
            if (accept) begin
               if (MULTI_CYCLE) begin
                  state_d    = WAIT;
                  timer_load = 1'b1;
               end else begin
                  state_d = RESP;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (timer_done) begin
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Stores and error requests answer with zero data; loads capture the word at accept.
   always_comb begin
      hold_d = hold_q;
      if (accept) begin
         hold_d = (req_write || req_err) ? '0 : mem_q[req_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      hold_q <= hold_d;
   end

   always_ff @(posedge clk) begin
      if (accept && req_write && !req_err) begin
         mem_q[req_idx] <= req_wdata;
      end
   end

endmodule
